timer_ctrl: RTL
===============

Name: timer_ctrl

Overview:
- Programmable timer controller that sequences an 8-bit up-counter. It adds configuration capture, a clock prescaler, start/stop/pause control, and one-shot or periodic terminal-count operation.
- Sits between a host/control FSM and any logic needing timed events.
- Produces a per-increment tick pulse and a terminal-count done pulse.

Parameters:
- WIDTH, 8, counter and period width.
- PRESC_W, 8, prescaler reload width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- cfg_valid_i  input  1  configuration offered.
- cfg_ready_o  output  1  controller accepts configuration (IDLE or DONE only).
- period_i  input  WIDTH  terminal count value.
- prescale_i  input  PRESC_W  counter increments every prescale_i+1 clocks.
- periodic_i  input  1  1 = auto-restart at terminal count, 0 = one-shot.
- start_i  input  1  start pulse/level.
- stop_i  input  1  abort, return to IDLE.
- pause_i  input  1  level; freeze while high.
- counter_o  output  WIDTH  current count.
- tick_o  output  1  one-cycle pulse per counter update.
- done_o  output  1  one-cycle pulse per terminal count.
- busy_o  output  1  high in RUN or HOLD.
- state_o  output  2  IDLE=00, RUN=01, HOLD=10, DONE=11.

Behaviour:
- Reset (async, active-low):
  - state IDLE, counter_o=0, prescaler count=0.
  - period_reg=all ones, prescale_reg=0, periodic_reg=0.
  - tick_o=0, done_o=0, busy_o=0, cfg_ready_o=1.
  - Reset mid-run aborts immediately to these values.
- All outputs are registered. cfg_ready_o = (state==IDLE || state==DONE).
- Config handshake: on an edge with cfg_valid_i && cfg_ready_o, capture period_i, prescale_i and periodic_i into the shadow registers. While not ready, cfg_valid_i is ignored and the registers hold.
- IDLE/DONE with start_i=1 -> RUN:
  - counter and prescaler count cleared.
  - If cfg_valid_i is accepted on the same edge, the new config governs this run.
  - DONE without start_i holds counter_o at the period value.
- RUN:
  - prescaler count increments each clock.
  - When it equals prescale_reg: prescaler count clears and a tick event occurs.
  - Tick with counter!=period_reg: counter+1, tick_o=1 the next cycle.
  - Tick with counter==period_reg (terminal): tick_o=1 and done_o=1 the next cycle.
    - Periodic: counter wraps to 0, stay RUN.
    - One-shot: counter holds period_reg, go to DONE.
  - A full cycle covers period_reg+1 ticks. period_reg=0 means done on every tick.
  - prescale_reg=0 means a tick every clock.
- RUN with pause_i=1 -> HOLD. HOLD with pause_i=0 -> RUN.
  - In HOLD, counter and prescaler count are frozen and no tick/done is issued.
  - A tick due on the pausing edge is suppressed.
- stop_i in RUN or HOLD -> IDLE, counter and prescaler count cleared, no done_o.
- Priority on the same edge: rst_ni > stop_i > pause_i > tick/terminal.
- start_i is ignored in RUN/HOLD. stop_i and pause_i are ignored in IDLE/DONE.
- Arithmetic is unsigned. The counter never exceeds period_reg, so there is no natural overflow except when period_reg = all ones, where the terminal count is 255.

Test Plan:
- Reset held 100 ns with a 50 MHz clock, then released:
  - required: counter_o=0, state_o=00, cfg_ready_o=1, busy_o=0.
  - then start with default config: counter counts 0..255.
  - done_o pulses once as counter_o returns to 0? No: default periodic=0, so state goes to DONE with counter_o=255.
- Config period=3, prescale=0, periodic=1, then start:
  - counter sequence 1,2,3,0,1,2,3,0.
  - tick_o high every cycle; done_o high in each cycle where counter_o=0.
- Config period=2, prescale=3, periodic=0, then start:
  - counter increments every 4 clocks: 1 at clock 4, 2 at clock 8.
  - terminal at clock 12: done_o=1, state DONE, counter_o=2 held.
  - cfg_ready_o=1 afterwards.
- Pause mid-run (period=10, prescale=0), pause_i high 5 cycles at counter=4:
  - state HOLD, counter stays 4, no tick_o.
  - after release, counter resumes 5,6,...
- stop_i asserted together with pause_i at counter=7:
  - required: state IDLE, counter_o=0, no done_o.
- cfg_valid_i with period=9 while in RUN:
  - not accepted, cfg_ready_o=0, run completes with the old period.
- rst_ni asserted mid-RUN asynchronously:
  - outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// Configuration handshake bundle for timer_ctrl: host offers period/prescale/mode,
// controller signals when it will capture them.
interface timer_ctrl_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 8
);
  logic               cfg_valid_i;
  logic               cfg_ready_o;
  logic [WIDTH-1:0]   period_i;
  logic [PRESC_W-1:0] prescale_i;
  logic               periodic_i;

  modport master (
    output cfg_valid_i, period_i, prescale_i, periodic_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i, period_i, prescale_i, periodic_i,
    output cfg_ready_o
  );
endinterface

// File: rtl/timer_ctrl.sv
// Programmable timer: prescaled up-counter with start/stop/pause control and
// one-shot or periodic terminal count, configured through timer_ctrl_if.
module timer_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  timer_ctrl_if.slave      cfg,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             pause_i,
  output logic [WIDTH-1:0] counter_o,
  output logic             tick_o,
  output logic             done_o,
  output logic             busy_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_cnt, w_cnt_nxt;
  logic [PRESC_W-1:0] r_pcnt, w_pcnt_nxt;
  logic [WIDTH-1:0]   r_period;
  logic [PRESC_W-1:0] r_presc;
  logic               r_periodic;
  logic               r_tick, w_tick_nxt;
  logic               r_done, w_done_nxt;
  logic               w_ready;
  logic               w_cfg_acc;

  assign w_ready   = (r_state == IDLE) || (r_state == DONE);
  assign w_cfg_acc = cfg.cfg_valid_i && w_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_pcnt     <= '0;
      r_period   <= '1;
      r_presc    <= '0;
      r_periodic <= 1'b0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_tick  <= w_tick_nxt;
      r_done  <= w_done_nxt;
      if (w_cfg_acc) begin
        r_period   <= cfg.period_i;
        r_presc    <= cfg.prescale_i;
        r_periodic <= cfg.periodic_i;
      end
    end
  end

  // Start clears the counters; a config accepted on the same edge lands in the
  // shadow registers before the first prescaler compare, so it governs the run.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pcnt_nxt  = r_pcnt;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (start_i) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
          w_pcnt_nxt  = '0;
        end
      end
      RUN: begin
        if (stop_i) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_pcnt_nxt  = '0;
        end else if (pause_i) begin
          w_state_nxt = HOLD;
        end else if (r_pcnt == r_presc) begin
          w_pcnt_nxt = '0;
          w_tick_nxt = 1'b1;
          if (r_cnt == r_period) begin
            w_done_nxt = 1'b1;
            if (r_periodic) w_cnt_nxt = '0;
            else            w_state_nxt = DONE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          w_pcnt_nxt = r_pcnt + 1'b1;
        end
      end
      HOLD: begin
        if (stop_i) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_pcnt_nxt  = '0;
        end else if (!pause_i) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign cfg.cfg_ready_o = w_ready;
  assign counter_o       = r_cnt;
  assign tick_o          = r_tick;
  assign done_o          = r_done;
  assign busy_o          = (r_state == RUN) || (r_state == HOLD);
  assign state_o         = r_state;

endmodule
